ahb_imem_subordinate: RTL and testbench
=======================================

Name: ahb_imem_subordinate

Overview:
AHB-Lite subordinate (responder) that serves instruction fetches from an on-chip word-addressed memory. It is the far end of the instruction-cache line-fill transfers. It decodes each address phase, inserts a programmable number of wait states, returns read data, and issues the two-cycle ERROR response for unsupported transfers. A side load port lets the memory be preloaded (boot image or testbench).

Parameters:
ADDR_WIDTH, 32, AHB address width.
DATA_WIDTH, 32, AHB data width; only word transfers are supported.
MEM_DEPTH_LOG2, 10, log2 of the memory depth in words (default 4 KiB).
WAIT_STATES, 1, wait cycles inserted before each read data beat (0..15).
BASE_ADDR, 32'h0000_0000, byte base address of the memory; must be word-aligned.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
HSEL  in  1  subordinate select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  transfer type: IDLE/BUSY/NONSEQ/SEQ
HWRITE  in  1  write flag
HSIZE  in  3  transfer size
HBURST  in  3  burst type (decoded, no effect on behaviour)
HWDATA  in  DATA_WIDTH  write data (ignored)
HREADY  in  1  bus-level ready (HREADYIN)
HREADYOUT  out  1  subordinate ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  DATA_WIDTH  read data
ld_en  in  1  preload write enable
ld_addr  in  MEM_DEPTH_LOG2  preload word index
ld_data  in  DATA_WIDTH  preload word

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=ST_IDLE, wait counter=0. Memory contents are not cleared.
- Acceptance: a transfer is accepted on a rising edge when HSEL & HREADY & HTRANS[1] are all true (NONSEQ or SEQ). IDLE, BUSY, HSEL=0 or HREADY=0 accept nothing.
- Error classification (at acceptance): the transfer is an error when any of these holds:
  - HWRITE=1;
  - HSIZE != 3'b010;
  - HADDR[1:0] != 0;
  - HADDR < BASE_ADDR, or HADDR - BASE_ADDR >= 4 * 2^MEM_DEPTH_LOG2.
- Word index: idx = (HADDR - BASE_ADDR) >> 2, registered at acceptance.
- States:
  - ST_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
    - On acceptance: error -> ST_ERR1; WAIT_STATES=0 -> ST_RD; else ST_WAIT with cnt=WAIT_STATES.
  - ST_WAIT: HREADYOUT=0, HRESP=0. cnt decrements each cycle; at cnt==1 -> ST_RD.
  - ST_RD: HREADYOUT=1, HRESP=0, HRDATA=mem[idx].
    - The next transfer may be accepted in the same cycle (pipelined), with the same transitions as ST_IDLE.
    - No acceptance -> ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=1; always -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1. Accepts a new transfer like ST_IDLE (the master normally drives IDLE here); otherwise -> ST_IDLE.
- Memory read: the RAM read is issued in the cycle before ST_RD, i.e. the acceptance cycle when WAIT_STATES=0, otherwise the last ST_WAIT cycle. RAM read latency is 1 cycle.
- Bursts: every beat carries its own address, so SEQ is decoded exactly like NONSEQ. WRAP/INCR boundaries need no internal tracking.
- Read-then-error in a pipeline: the read data beat completes OKAY, and the error transfer enters ST_ERR1 on the next edge.
- Load collision: ld_en to the word being read in the same cycle is read-first, so the old data is returned. ld_en is allowed in any state and does not affect bus timing.
- Reset mid-transfer: next cycle is ST_IDLE with the outputs at their reset values. The transfer in flight is dropped.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_WORD=3'b010;
  - HRESP_OKAY/ERROR;
  - HBURST codes.
- ahb_pkg is shared with the instruction-cache master. The state enum stays local to this block.
- Sub-module imem_ram_1r1w: synchronous read port plus preload write port, read-first, depth 2^MEM_DEPTH_LOG2.

Test Plan:
- Preload mem[0..3]=0xA0..0xA3, WAIT_STATES=1; NONSEQ read of 0x8 -> one cycle HREADYOUT=0, then HREADYOUT=1, HRDATA=0x000000A2, HRESP=0.
- INCR4 burst 0x0/0x4/0x8/0xC (NONSEQ + 3 SEQ) -> beats 0xA0, 0xA1, 0xA2, 0xA3 in order, each preceded by exactly one wait cycle. With WAIT_STATES=0 -> four back-to-back zero-wait beats.
- NONSEQ write to 0x4 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. A following read of 0x4 returns 0xA1.
- Each of the following gives the two-cycle ERROR: read at 0x2 (misaligned); read at 0x1000 (out of range for depth 1024); HSIZE=3'b000.
- HTRANS=BUSY, HSEL=0, or NONSEQ with HREADY=0 -> HREADYOUT=1, HRESP=0, no state change. ld_en to word 2 during a read of 0x8 in its RAM-read cycle -> old value 0xA2 returned.
- rst asserted during ST_WAIT -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0. A subsequent read of 0x0 returns 0xA0 (memory preserved).

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the instruction-cache master and memory side.
// Transfer type, size, response and burst codes; no ports.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Instruction memory array: registered read port, preload write port.
// Ports: clk, re/raddr/rdata (read), we/waddr/wdata (preload). Read-first.
module imem_ram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Both updates are non-blocking, so a same-cycle write to the
  // read address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_imem_subordinate.sv
// AHB-Lite read-only instruction memory with wait states and ERROR response.
// Ports: clk, rst, AHB subordinate signals, ld_en/ld_addr/ld_data preload.
module ahb_imem_subordinate
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int WAIT_STATES    = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      HSEL,
  input  logic [ADDR_WIDTH-1:0]     HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [DATA_WIDTH-1:0]     HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_WIDTH-1:0]     HRDATA,
  input  logic                      ld_en,
  input  logic [MEM_DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data
);

  localparam int AW = MEM_DEPTH_LOG2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_RD, ST_ERR1, ST_ERR2
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] idx, idx_n;

  logic [ADDR_WIDTH-1:0] off;
  logic borrow;
  logic slot_open;
  logic acc;
  logic err;
  logic [AW-1:0] new_idx;
  logic re;
  logic [AW-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_bits;

  // Borrow out flags addresses below the base.
  assign {borrow, off} = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign new_idx = off[AW+1:2];

  assign slot_open = (state == ST_IDLE) || (state == ST_RD)
                  || (state == ST_ERR2);
  assign acc = slot_open & HSEL & HREADY & HTRANS[1];

  assign err = HWRITE
            | (HSIZE != HSIZE_WORD)
            | (HADDR[1:0] != 2'b00)
            | borrow
            | (off[ADDR_WIDTH-1:AW+2] != '0);

  // Bursts carry full addresses; burst type and write data are not needed.
  assign unused_bits = ^{HTRANS[0], HBURST, HWDATA, off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    re      = 1'b0;
    raddr   = idx;
    unique case (state)
      ST_IDLE, ST_RD, ST_ERR2: begin
        state_n = ST_IDLE;
        if (acc) begin
          idx_n = new_idx;
          if (err) begin
            state_n = ST_ERR1;
          end else if (WS == 4'd0) begin
            // Zero wait: RAM read happens in the acceptance cycle.
            state_n = ST_RD;
            re      = 1'b1;
            raddr   = new_idx;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = WS;
          end
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = ST_RD;
          re      = 1'b1;
        end
      end
      ST_ERR1: state_n = ST_ERR2;
      default: state_n = ST_IDLE;
    endcase
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2))
               ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = (state == ST_RD) ? rdata : '0;

  imem_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (AW)
  ) u_ram (
    .clk   (clk),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data)
  );

endmodule

// File: tb/tb_ahb_imem_subordinate.sv
// Directed bench for ahb_imem_subordinate: one instance with one wait state,
// one with zero wait states; expected values are hand-computed constants.
module tb_ahb_imem_subordinate;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        ovr;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        ro0, resp0, ro1, resp1;
  logic [31:0] rd0, rd1;
  logic        hready0, hready1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign hready0 = ovr ? 1'b0 : ro0;
  assign hready1 = ro1;

  ahb_imem_subordinate #(.WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .HSEL(sel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready0),
    .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  ahb_imem_subordinate #(.WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .HSEL(sel1), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready1),
    .HREADYOUT(ro1), .HRESP(resp1), .HRDATA(rd1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] full0();
    return {ro0, resp0, rd0};
  endfunction

  function automatic logic [33:0] hs0();
    return {ro0, resp0, 32'h0};
  endfunction

  task automatic aphase(input logic [31:0] a, input logic [1:0] t,
                        input logic w, input logic [2:0] s);
    haddr  = a;
    htrans = t;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic idle();
    aphase(32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
  endtask

  task automatic do_err(input string tag, input logic [31:0] a,
                        input logic w, input logic [2:0] s);
    aphase(a, HTRANS_NONSEQ, w, s);
    tick();
    chk({tag, "_err1"}, hs0(), {1'b0, 1'b1, 32'h0});
    idle();
    tick();
    chk({tag, "_err2"}, hs0(), {1'b1, 1'b1, 32'h0});
    tick();
    chk({tag, "_idle"}, full0(), {1'b1, 1'b0, 32'h0});
  endtask

  initial begin
    rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; ovr = 1'b0;
    hburst = HBURST_SINGLE; hwdata = 32'h0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle();

    // preload under reset
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1;
      ld_addr = 10'(i);
      ld_data = 32'hA0 + 32'(i);
      tick();
    end
    ld_en = 1'b0;
    tick();
    chk("reset0", full0(), {1'b1, 1'b0, 32'h0});
    chk("reset1", {ro1, resp1, rd1}, {1'b1, 1'b0, 32'h0});
    rst = 1'b0;
    sel0 = 1'b1;
    tick();

    // single read with one wait state
    aphase(32'h8, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    chk("rd8_wait", hs0(), {1'b0, 1'b0, 32'h0});
    idle();
    tick();
    chk("rd8_data", full0(), {1'b1, 1'b0, 32'hA2});
    tick();
    chk("rd8_idle", full0(), {1'b1, 1'b0, 32'h0});

    // INCR4 burst, one wait per beat
    hburst = HBURST_INCR4;
    aphase(32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("burst_wait", hs0(), {1'b0, 1'b0, 32'h0});
      if (i < 3)
        aphase(32'(4 * (i + 1)), HTRANS_SEQ, 1'b0, HSIZE_WORD);
      else
        idle();
      tick();
      chk("burst_data", full0(), {1'b1, 1'b0, 32'hA0 + 32'(i)});
      tick();
    end
    chk("burst_end", full0(), {1'b1, 1'b0, 32'h0});

    // INCR4 burst, zero wait states
    sel0 = 1'b0;
    sel1 = 1'b1;
    aphase(32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3)
        aphase(32'(4 * (i + 1)), HTRANS_SEQ, 1'b0, HSIZE_WORD);
      else
        idle();
      chk("zw_beat", {ro1, resp1, rd1}, {1'b1, 1'b0, 32'hA0 + 32'(i)});
    end
    tick();
    chk("zw_end", {ro1, resp1, rd1}, {1'b1, 1'b0, 32'h0});
    sel1 = 1'b0;
    sel0 = 1'b1;
    hburst = HBURST_SINGLE;

    // write is an error, memory unchanged
    do_err("write4", 32'h4, 1'b1, HSIZE_WORD);
    aphase(32'h4, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    chk("rd4_wait", hs0(), {1'b0, 1'b0, 32'h0});
    idle();
    tick();
    chk("rd4_data", full0(), {1'b1, 1'b0, 32'hA1});
    tick();

    do_err("misalign", 32'h2, 1'b0, HSIZE_WORD);
    do_err("range", 32'h1000, 1'b0, HSIZE_WORD);
    do_err("byte", 32'h0, 1'b0, 3'b000);

    // nothing accepted
    aphase(32'h8, HTRANS_BUSY, 1'b0, HSIZE_WORD);
    tick();
    chk("busy", full0(), {1'b1, 1'b0, 32'h0});
    aphase(32'h8, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    sel0 = 1'b0;
    tick();
    chk("nosel", full0(), {1'b1, 1'b0, 32'h0});
    sel0 = 1'b1;
    ovr = 1'b1;
    tick();
    chk("nordy", full0(), {1'b1, 1'b0, 32'h0});
    ovr = 1'b0;
    idle();
    tick();

    // preload collides with RAM read: old word returned
    aphase(32'h8, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    chk("coll_wait", hs0(), {1'b0, 1'b0, 32'h0});
    ld_en = 1'b1;
    ld_addr = 10'd2;
    ld_data = 32'h55;
    idle();
    tick();
    ld_en = 1'b0;
    chk("coll_old", full0(), {1'b1, 1'b0, 32'hA2});
    aphase(32'h8, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idle();
    tick();
    chk("coll_new", full0(), {1'b1, 1'b0, 32'h55});
    tick();

    // reset during wait state
    aphase(32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    chk("rst_wait", hs0(), {1'b0, 1'b0, 32'h0});
    rst = 1'b1;
    idle();
    tick();
    chk("rst_mid", full0(), {1'b1, 1'b0, 32'h0});
    rst = 1'b0;
    tick();
    chk("rst_hold", full0(), {1'b1, 1'b0, 32'h0});
    aphase(32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    chk("post_wait", hs0(), {1'b0, 1'b0, 32'h0});
    idle();
    tick();
    chk("post_data", full0(), {1'b1, 1'b0, 32'hA0});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
